// File: rtl/uart_rx_if.sv
// Line-side bundle for uart_rx: the serial input plus the received-word strobes.
// The line driver owns in_rx (master); the receiver owns the result signals (slave).
interface uart_rx_if #(
   parameter int DATA_W = 6
);
   logic              in_rx;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_frame_err;
   logic              out_busy;

   modport master (
      output in_rx,
      input  out_data, out_valid, out_frame_err, out_busy
   );

   modport slave (
      input  in_rx,
      output out_data, out_valid, out_frame_err, out_busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_W data bits LSB first, 1 stop bit, sampled at
// mid-bit with a cycle-counting bit timer. Good words strobe out_valid, bad stop bits strobe out_frame_err.
module uart_rx #(
   parameter int DATA_W       = 6,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic     in_clk,
   input  logic     in_rst,
   uart_rx_if.slave rx_if
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t            r_state;
   logic              r_sync1;
   logic              r_sync2;
   logic [TW-1:0]     r_timer;
   logic [BW-1:0]     r_bit_idx;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_frame_err;
   logic              r_busy;
   logic              w_rx_s;

   // Sync flops reset to the idle line level so release never looks like a start bit.
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments give a true two-stage shift; blocking would collapse it to one flop.
         r_sync1 <= rx_if.in_rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_s = r_sync2;

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_timer <= '0;
               if (!w_rx_s) begin
                  r_state <= S_START;
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (r_timer == HALF_LAST) begin
                  r_timer   <= '0;
                  r_bit_idx <= '0;
                  if (!w_rx_s) begin
                     r_state <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_DATA: begin
               if (r_timer == BIT_LAST) begin
                  r_timer   <= '0;
                  r_shift   <= {w_rx_s, r_shift[DATA_W-1:1]};
                  r_bit_idx <= r_bit_idx + BW'(1);
                  if (r_bit_idx == IDX_LAST) r_state <= S_STOP;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_STOP: begin
               if (r_timer == BIT_LAST) begin
                  r_timer <= '0;
                  if (w_rx_s) begin
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_WAIT_IDLE;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_WAIT_IDLE: begin
               // A held-low line (break) must return high before another frame is armed.
               r_timer <= '0;
               if (w_rx_s) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_timer <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_if.out_data      = r_data;
   assign rx_if.out_valid     = r_valid;
   assign rx_if.out_frame_err = r_frame_err;
   assign rx_if.out_busy      = r_busy;
endmodule
